// File: rtl/pp_buf_drain.sv
// Reader side of a two-bank ping-pong buffer: drains each full bank of a sync
// dual-port RAM onto a valid/ready byte stream and hands the bank back via r_done.
module pp_buf_drain #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        status_vld,
    input  logic [DATA_W-1:0] r_data,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic [1:0]        r_done,
    output logic              busy,
    output logic              error
);
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              cur_bank_q, cur_bank_d;
    logic              next_bank_q, next_bank_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]        clr_wait_q, clr_wait_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              err_q, err_d;
    logic              err_seen_q, err_seen_d;
    logic [1:0]        status_prev_q;

    logic [1:0]        eligible;
    logic              in_drain;
    logic              viol;
    logic [ADDR_W-1:0] addr;

    assign eligible = status_vld & ~clr_wait_q;
    assign in_drain = (state_q == S_FETCH) || (state_q == S_CAPT) || (state_q == S_HOLD);
    // Writer pulling the bank we are draining is flagged once per drain only.
    assign viol     = in_drain && !status_vld[cur_bank_q] && !err_seen_q;
    assign addr     = (cur_bank_q ? ADDR_W'(DEPTH) : '0) + ADDR_W'(word_cnt_q);

    always_comb begin
        state_d     = state_q;
        cur_bank_d  = cur_bank_q;
        next_bank_d = next_bank_q;
        word_cnt_d  = word_cnt_q;
        dout_d      = dout_q;
        dout_vld_d  = dout_vld_q;
        err_seen_d  = err_seen_q | viol;
        err_d       = viol || (status_vld == 2'b11 && status_prev_q == 2'b00);
        // A bank stays masked after its drain until the writer is seen to let go.
        clr_wait_d  = clr_wait_q & status_vld;

        case (state_q)
            S_IDLE: begin
                if (eligible[next_bank_q] || eligible[~next_bank_q]) begin
                    cur_bank_d = eligible[next_bank_q] ? next_bank_q : ~next_bank_q;
                    word_cnt_d = '0;
                    err_seen_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_CAPT;
            S_CAPT: begin
                dout_d     = r_data;
                dout_vld_d = 1'b1;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (dout_rdy) begin
                    dout_vld_d = 1'b0;
                    if (word_cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                clr_wait_d[cur_bank_q] = 1'b1;
                next_bank_d            = ~cur_bank_q;
                state_d                = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cur_bank_q    <= 1'b0;
            next_bank_q   <= 1'b0;
            word_cnt_q    <= '0;
            clr_wait_q    <= 2'b00;
            dout_q        <= '0;
            dout_vld_q    <= 1'b0;
            err_q         <= 1'b0;
            err_seen_q    <= 1'b0;
            status_prev_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            cur_bank_q    <= cur_bank_d;
            next_bank_q   <= next_bank_d;
            word_cnt_q    <= word_cnt_d;
            clr_wait_q    <= clr_wait_d;
            dout_q        <= dout_d;
            dout_vld_q    <= dout_vld_d;
            err_q         <= err_d;
            err_seen_q    <= err_seen_d;
            status_prev_q <= status_vld;
        end
    end

    assign r_en     = (state_q == S_FETCH);
    assign r_addr   = r_en ? addr : '0;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign r_done   = (state_q == S_DONE) ? (cur_bank_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy     = (state_q != S_IDLE);
    assign error    = err_q;

endmodule

// File: tb/tb_pp_buf_drain.sv
// Directed bench for pp_buf_drain: behavioural sync RAM on the read port and
// cycle-exact expectations for drain order, stalls, masking, errors and reset.
module tb_pp_buf_drain;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] status_vld;
    logic [7:0] r_data;
    logic       r_en;
    logic [3:0] r_addr;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic [1:0] r_done;
    logic       busy;
    logic       error;

    logic [7:0] mem [16];
    int n_assert = 0;
    int n_fail   = 0;

    pp_buf_drain #(.DATA_W(8), .ADDR_W(4), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .status_vld(status_vld), .r_data(r_data),
        .r_en(r_en), .r_addr(r_addr), .dout(dout), .dout_vld(dout_vld),
        .dout_rdy(dout_rdy), .r_done(r_done), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (r_en) r_data <= mem[r_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut(input logic [1:0] s);
        rst = 1'b1;
        status_vld = s;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int nw, nd;
        logic [7:0] got [4];
        logic [1:0] dones [2];
        logic [1:0] prev_done;

        r_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;

        // 1: reset with both banks full
        rst = 1'b1; status_vld = 2'b11; dout_rdy = 1'b1;
        repeat (3) tick();
        chk("rst_r_en", 32'(r_en), 0);
        chk("rst_r_addr", 32'(r_addr), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dout_vld", 32'(dout_vld), 0);
        chk("rst_r_done", 32'(r_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_error", 32'(error), 0);

        // 2: single bank0 drain, cycle-exact
        status_vld = 2'b01;
        tick();
        rst = 1'b0;
        tick();
        chk("t2_c1_r_en", 32'(r_en), 1);
        chk("t2_c1_r_addr", 32'(r_addr), 0);
        chk("t2_c1_busy", 32'(busy), 1);
        tick();
        chk("t2_c2_r_en", 32'(r_en), 0);
        chk("t2_c2_vld", 32'(dout_vld), 0);
        tick();
        chk("t2_c3_vld", 32'(dout_vld), 1);
        chk("t2_c3_dout", 32'(dout), 'h12);
        tick();
        chk("t2_c4_r_en", 32'(r_en), 1);
        chk("t2_c4_r_addr", 32'(r_addr), 1);
        chk("t2_c4_vld", 32'(dout_vld), 0);
        tick(); tick();
        chk("t2_c6_vld", 32'(dout_vld), 1);
        chk("t2_c6_dout", 32'(dout), 'h34);
        tick();
        chk("t2_c7_r_done", 32'(r_done), 'h1);
        chk("t2_c7_error", 32'(error), 0);
        tick();
        chk("t2_c8_r_done", 32'(r_done), 0);
        chk("t2_c8_busy", 32'(busy), 0);
        status_vld = 2'b00;
        tick();

        // 3: both banks full, strict alternation starting at bank0
        reset_dut(2'b11);
        nw = 0; nd = 0; prev_done = 2'b00;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (dout_vld && dout_rdy) begin
                if (nw < 4) got[nw] = dout;
                nw++;
            end
            if (r_done != 2'b00) begin
                if (nd < 2) dones[nd] = r_done;
                nd++;
                status_vld = status_vld & ~r_done;
            end
            chk("t3_done_consec", 32'(r_done != 2'b00 && prev_done != 2'b00), 0);
            prev_done = r_done;
        end
        chk("t3_words", 32'(nw), 4);
        chk("t3_w0", 32'(got[0]), 'h12);
        chk("t3_w1", 32'(got[1]), 'h34);
        chk("t3_w2", 32'(got[2]), 'h56);
        chk("t3_w3", 32'(got[3]), 'h78);
        chk("t3_ndone", 32'(nd), 2);
        chk("t3_done0", 32'(dones[0]), 'h1);
        chk("t3_done1", 32'(dones[1]), 'h2);

        // 4: consumer stalls 5 cycles on the first word
        dout_rdy = 1'b0;
        reset_dut(2'b01);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_dout", 32'(dout), 'h12);
            chk("t4_stall_vld", 32'(dout_vld), 1);
            chk("t4_stall_r_en", 32'(r_en), 0);
            if (i == 4) dout_rdy = 1'b1;
            tick();
        end
        chk("t4_c8_r_en", 32'(r_en), 1);
        chk("t4_c8_r_addr", 32'(r_addr), 1);
        chk("t4_c8_vld", 32'(dout_vld), 0);
        tick(); tick();
        chk("t4_c10_dout", 32'(dout), 'h34);
        tick();
        chk("t4_c11_r_done", 32'(r_done), 'h1);
        status_vld = 2'b00;
        tick();

        // 5: slow writer release must not trigger a second drain; refill does
        reset_dut(2'b01);
        repeat (7) tick();
        chk("t5_r_done", 32'(r_done), 'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_masked_busy", 32'(busy), 0);
            chk("t5_masked_r_done", 32'(r_done), 0);
        end
        status_vld = 2'b00;
        tick();
        chk("t5_low_busy", 32'(busy), 0);
        mem[0] = 8'hA5;
        status_vld = 2'b01;
        tick();
        chk("t5_refill_r_en", 32'(r_en), 1);
        chk("t5_refill_r_addr", 32'(r_addr), 0);
        tick(); tick();
        chk("t5_refill_dout", 32'(dout), 'hA5);
        chk("t5_refill_vld", 32'(dout_vld), 1);
        repeat (4) tick();
        chk("t5_refill_r_done", 32'(r_done), 'h1);
        status_vld = 2'b00;
        tick();

        // 6a: writer drops bank0 while its first word is held
        reset_dut(2'b01);
        repeat (3) tick();
        chk("t6_hold_vld", 32'(dout_vld), 1);
        status_vld = 2'b00;
        tick();
        chk("t6_err_pulse", 32'(error), 1);
        chk("t6_c4_r_addr", 32'(r_addr), 1);
        tick();
        chk("t6_err_once", 32'(error), 0);
        tick();
        chk("t6_c6_dout", 32'(dout), 'h34);
        tick();
        chk("t6_r_done", 32'(r_done), 'h1);
        chk("t6_c7_error", 32'(error), 0);
        tick();
        chk("t6_c8_busy", 32'(busy), 0);

        // 6b: reset mid-drain aborts without r_done, then re-drains from word 0
        reset_dut(2'b01);
        repeat (3) tick();
        chk("t6b_hold_vld", 32'(dout_vld), 1);
        rst = 1'b1;
        #1;
        chk("t6b_abort_busy", 32'(busy), 0);
        chk("t6b_abort_vld", 32'(dout_vld), 0);
        chk("t6b_abort_r_done", 32'(r_done), 0);
        tick(); tick();
        chk("t6b_inrst_r_done", 32'(r_done), 0);
        rst = 1'b0;
        tick();
        chk("t6b_redrain_r_en", 32'(r_en), 1);
        chk("t6b_redrain_r_addr", 32'(r_addr), 0);
        repeat (6) tick();
        chk("t6b_r_done", 32'(r_done), 'h1);
        status_vld = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
